// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA peripheral port.
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACK,
        STRB,
        DONE
    } port_state_t;

    localparam logic DIR_P2M = 1'b0;
    localparam logic DIR_M2P = 1'b1;

endpackage

// File: rtl/dma_peripheral_port_if.sv
// DMA channel bus between controller (master) and peripheral (slave).
interface dma_peripheral_port_if #(
    parameter int unsigned DW = 8
);
    logic          DREQ;
    logic          DACK;
    logic          IOR_N;
    logic          IOW_N;
    logic          EOP_N;
    logic [DW-1:0] db_in;
    logic [DW-1:0] db_out;
    logic          db_oe;

    modport master (
        input  DREQ, db_out, db_oe,
        output DACK, IOR_N, IOW_N, EOP_N, db_in
    );

    modport slave (
        output DREQ, db_out, db_oe,
        input  DACK, IOR_N, IOW_N, EOP_N, db_in
    );
endinterface

// File: rtl/dma_periph_fifo.sv
// Single-clock FIFO; push while full is accepted only when a pop frees the slot in the same cycle.
module dma_periph_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [DW-1:0]          wdata,
    input  logic                   pop,
    output logic [DW-1:0]          rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];
    assign level = count;

endmodule

// File: rtl/dma_peripheral_port.sv
// Peripheral-side DMA responder: raises DREQ on FIFO level, serves IOR_N/IOW_N strobes, honours EOP_N.
module dma_peripheral_port
    import dma_pkg::*;
#(
    parameter int unsigned DW     = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned THRESH = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 en,
    input  logic                 dir,
    input  logic                 demand,
    input  logic                 clr_tc,
    dma_peripheral_port_if.slave bus,
    input  logic                 s_valid,
    input  logic [DW-1:0]        s_data,
    output logic                 s_ready,
    output logic                 m_valid,
    output logic [DW-1:0]        m_data,
    input  logic                 m_ready,
    output logic [15:0]          xfer_cnt,
    output logic                 tc_done,
    output logic                 err
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    port_state_t   state, state_nx;
    logic          dreq_q, dreq_nx;
    logic          ior_q, iow_q;
    logic          tc_q, err_q;
    logic [15:0]   cnt_q;
    logic [DW-1:0] cap_q;

    logic          strb_n, strb_q, strb_fall, strb_rise;
    logic          level_ok, eop, xfer;
    logic          loc_push, loc_pop, bus_push, bus_pop;
    logic          underrun, overflow;
    logic          fifo_push, fifo_pop, full, empty;
    logic [DW-1:0] fifo_wdata, head;
    logic [LW-1:0] level;

    // Edge detection on whichever strobe the direction selects
    assign strb_n    = (dir == DIR_M2P) ? bus.IOW_N : bus.IOR_N;
    assign strb_q    = (dir == DIR_M2P) ? iow_q : ior_q;
    assign strb_fall = strb_q && !strb_n;
    assign strb_rise = !strb_q && strb_n;

    // Level is the registered occupancy, before any transfer completing this cycle
    assign level_ok = (dir == DIR_P2M) ? (level >= LW'(THRESH))
                                       : ((LW'(DEPTH) - level) >= LW'(THRESH));
    assign eop      = !bus.EOP_N && bus.DACK;
    assign xfer     = en && (state == STRB) && strb_rise;

    assign loc_push = (dir == DIR_P2M) && s_valid && !full;
    assign loc_pop  = (dir == DIR_M2P) && m_ready && !empty;
    assign bus_pop  = xfer && (dir == DIR_P2M) && !empty;
    assign bus_push = xfer && (dir == DIR_M2P) && (!full || loc_pop);
    assign underrun = xfer && (dir == DIR_P2M) && empty;
    assign overflow = xfer && (dir == DIR_M2P) && full && !loc_pop;

    assign fifo_push  = (dir == DIR_P2M) ? loc_push : bus_push;
    assign fifo_pop   = (dir == DIR_P2M) ? bus_pop  : loc_pop;
    assign fifo_wdata = (dir == DIR_P2M) ? s_data   : cap_q;

    dma_periph_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESET),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Next-state and registered DREQ request
    always_comb begin
        state_nx = state;
        dreq_nx  = 1'b0;
        unique case (state)
            IDLE: if (!tc_q && level_ok) state_nx = REQ;
            REQ:  if (bus.DACK) state_nx = ACK;
            ACK: begin
                if (eop)            state_nx = DONE;
                else if (!bus.DACK) state_nx = IDLE;
                else if (strb_fall) state_nx = STRB;
            end
            STRB: begin
                if (eop)            state_nx = DONE;
                else if (strb_rise) state_nx = (demand && bus.DACK && level_ok) ? ACK : IDLE;
                else if (!bus.DACK) state_nx = IDLE;
            end
            DONE: if (clr_tc) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (!en) state_nx = IDLE;
        dreq_nx = (state_nx == REQ) || (state_nx == ACK) || (state_nx == STRB);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state  <= IDLE;
            dreq_q <= 1'b0;
            ior_q  <= 1'b1;
            iow_q  <= 1'b1;
            cnt_q  <= '0;
            tc_q   <= 1'b0;
            err_q  <= 1'b0;
            cap_q  <= '0;
        end else begin
            state  <= state_nx;
            dreq_q <= dreq_nx;
            ior_q  <= bus.IOR_N;
            iow_q  <= bus.IOW_N;
            tc_q   <= (state_nx == DONE);
            if (!bus.IOW_N) cap_q <= bus.db_in;
            if (xfer)       cnt_q <= cnt_q + 16'd1;
            if (clr_tc)                     err_q <= 1'b0;
            else if (underrun || overflow)  err_q <= 1'b1;
        end
    end

    // Read data is driven straight from the FIFO head while the read strobe is low
    assign bus.db_oe  = (state == STRB) && (dir == DIR_P2M) && !bus.IOR_N && bus.DACK;
    assign bus.db_out = (bus.db_oe && !empty) ? head : '0;
    assign bus.DREQ   = dreq_q;

    assign s_ready  = !full;
    assign m_valid  = !empty;
    assign m_data   = head;
    assign xfer_cnt = cnt_q;
    assign tc_done  = tc_q;
    assign err      = err_q;

endmodule
